// File: rtl/pan_pkg.sv
// Shared types and sizing for PAN digit capture: FSM states, error codes, buffer widths.
package pan_pkg;

  localparam int PAN_MAX_DIGITS = 19;
  localparam int PAN_MIN_DIGITS = 12;
  localparam int PAN_BCD_W      = 4 * PAN_MAX_DIGITS;
  localparam int PAN_LEN_W      = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2,
    ERROR   = 2'd3
  } pan_state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_BAD_DIGIT = 2'd1,
    ERR_OVERFLOW  = 2'd2,
    ERR_SHORT     = 2'd3
  } pan_err_t;

  function automatic logic is_bcd(input logic [3:0] d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/pan_digit_capture.sv
// Packs serial BCD digits leftmost-first; all outputs registered, ready/error one cycle after pan_end.
// digit_ready is low in DONE/ERROR, so new digits stall until clear.
module pan_digit_capture
  import pan_pkg::*;
#(
  parameter int MAX_DIGITS = PAN_MAX_DIGITS,
  parameter int MIN_DIGITS = PAN_MIN_DIGITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    digit_valid,
  input  logic [3:0]              digit_in,
  output logic                    digit_ready,
  input  logic                    pan_end,
  input  logic                    clear,
  output logic                    pan_ready,
  output logic [PAN_LEN_W-1:0]    len_final,
  output logic [4*MAX_DIGITS-1:0] pan_bcd,
  output logic                    pan_error,
  output logic [1:0]              err_code
);

  localparam logic [PAN_LEN_W-1:0] L_MAX = PAN_LEN_W'(MAX_DIGITS);
  localparam logic [PAN_LEN_W-1:0] L_MIN = PAN_LEN_W'(MIN_DIGITS);

  pan_state_t              r_state;
  pan_err_t                r_err;
  logic [PAN_LEN_W-1:0]    r_count;
  logic [PAN_LEN_W-1:0]    r_len;
  logic [4*MAX_DIGITS-1:0] r_bcd;
  logic                    r_ready;
  logic                    r_error;
  logic                    r_digit_ready;

  logic                    w_accept;
  logic                    w_bad;
  logic                    w_ovf;
  logic                    w_store;
  logic [PAN_LEN_W-1:0]    w_n;

  assign w_accept = digit_valid && r_digit_ready;
  assign w_bad    = w_accept && !is_bcd(digit_in);
  assign w_ovf    = w_accept && !w_bad && (r_count == L_MAX);
  assign w_store  = w_accept && !w_bad && !w_ovf;
  // Length seen by pan_end includes a digit stored on the same edge.
  assign w_n      = r_count + PAN_LEN_W'(w_store);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_err         <= ERR_NONE;
      r_count       <= '0;
      r_len         <= '0;
      r_bcd         <= '0;
      r_ready       <= 1'b0;
      r_error       <= 1'b0;
      r_digit_ready <= 1'b1;
    end else if (clear) begin
      r_state       <= IDLE;
      r_err         <= ERR_NONE;
      r_count       <= '0;
      r_len         <= '0;
      r_bcd         <= '0;
      r_ready       <= 1'b0;
      r_error       <= 1'b0;
      r_digit_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE, COLLECT: begin
          if (w_bad || w_ovf) begin
            r_state       <= ERROR;
            r_err         <= w_bad ? ERR_BAD_DIGIT : ERR_OVERFLOW;
            r_error       <= 1'b1;
            r_digit_ready <= 1'b0;
          end else begin
            if (w_store) begin
              r_bcd[{r_count, 2'b00} +: 4] <= digit_in;
              r_count                      <= w_n;
              r_state                      <= COLLECT;
            end
            if (pan_end) begin
              r_digit_ready <= 1'b0;
              if (w_n < L_MIN) begin
                r_state <= ERROR;
                r_err   <= ERR_SHORT;
                r_error <= 1'b1;
              end else begin
                r_state <= DONE;
                r_len   <= w_n;
                r_ready <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign digit_ready = r_digit_ready;
  assign pan_ready   = r_ready;
  assign len_final   = r_len;
  assign pan_bcd     = r_bcd;
  assign pan_error   = r_error;
  assign err_code    = r_err;

endmodule

// File: tb/tb_pan_digit_capture.sv
// Directed bench for pan_digit_capture with hand-computed expected values.
module tb_pan_digit_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic        digit_ready;
  logic        pan_end = 1'b0;
  logic        clear = 1'b0;
  logic        pan_ready;
  logic [4:0]  len_final;
  logic [75:0] pan_bcd;
  logic        pan_error;
  logic [1:0]  err_code;

  int n_checks = 0;
  int n_errors = 0;

  pan_digit_capture dut (
    .clk(clk), .rst(rst),
    .digit_valid(digit_valid), .digit_in(digit_in), .digit_ready(digit_ready),
    .pan_end(pan_end), .clear(clear),
    .pan_ready(pan_ready), .len_final(len_final), .pan_bcd(pan_bcd),
    .pan_error(pan_error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_digit(input logic [3:0] d, input logic with_end);
    digit_valid = 1'b1;
    digit_in    = d;
    pan_end     = with_end;
    step();
    digit_valid = 1'b0;
    digit_in    = 4'd0;
    pan_end     = 1'b0;
  endtask

  task automatic do_end();
    pan_end = 1'b1;
    step();
    pan_end = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, 80'(pan_ready), 80'd0);
    chk({tag, "_error"}, 80'(pan_error), 80'd0);
    chk({tag, "_code"},  80'(err_code),  80'd0);
    chk({tag, "_len"},   80'(len_final), 80'd0);
    chk({tag, "_bcd"},   80'(pan_bcd),   80'd0);
    chk({tag, "_drdy"},  80'(digit_ready), 80'd1);
  endtask

  logic [3:0] t1_digits [16] = '{4,5,3,9,1,4,8,8,0,3,4,3,6,4,6,7};
  logic [3:0] t2_digits [15] = '{1,2,3,4,5,6,7,8,9,0,1,2,3,4,5};
  logic [75:0] bcd_snap;

  initial begin
    #12;
    chk_idle("reset");
    rst = 1'b0;
    step();

    // 16-digit PAN, pan_end on its own cycle
    for (int i = 0; i < 16; i++) send_digit(t1_digits[i], 1'b0);
    chk("t1_no_ready_yet", 80'(pan_ready), 80'd0);
    do_end();
    chk("t1_ready", 80'(pan_ready), 80'd1);
    chk("t1_len", 80'(len_final), 80'd16);
    chk("t1_bcd", 80'(pan_bcd), 80'h0007646343088419354);
    chk("t1_nib0", 80'(pan_bcd[3:0]), 80'd4);
    chk("t1_nib15", 80'(pan_bcd[63:60]), 80'd7);
    chk("t1_upper", 80'(pan_bcd[75:64]), 80'd0);
    chk("t1_drdy", 80'(digit_ready), 80'd0);
    send_digit(4'd9, 1'b1);
    chk("t1_stable_bcd", 80'(pan_bcd), 80'h0007646343088419354);
    chk("t1_stable_len", 80'(len_final), 80'd16);
    chk("t1_stable_err", 80'(pan_error), 80'd0);
    do_clear();
    chk_idle("t1_clear");

    // 16th digit arrives together with pan_end
    for (int i = 0; i < 15; i++) send_digit(t2_digits[i], 1'b0);
    send_digit(4'd9, 1'b1);
    chk("t2_ready", 80'(pan_ready), 80'd1);
    chk("t2_len", 80'(len_final), 80'd16);
    chk("t2_bcd", 80'(pan_bcd), 80'h0009543210987654321);
    do_clear();

    // 19 digits fill the buffer, the 20th overflows
    for (int i = 0; i < 19; i++) send_digit(4'(i % 10), 1'b0);
    chk("t3_full_no_err", 80'(pan_error), 80'd0);
    send_digit(4'd5, 1'b0);
    chk("t3_error", 80'(pan_error), 80'd1);
    chk("t3_code", 80'(err_code), 80'd2);
    chk("t3_nib18", 80'(pan_bcd[75:72]), 80'd8);
    chk("t3_bcd", 80'(pan_bcd), 80'h8765432109876543210);
    chk("t3_ready", 80'(pan_ready), 80'd0);
    do_clear();

    // Non-BCD digit after three digits
    send_digit(4'd1, 1'b0);
    send_digit(4'd2, 1'b0);
    send_digit(4'd3, 1'b0);
    send_digit(4'hA, 1'b0);
    chk("t4_error", 80'(pan_error), 80'd1);
    chk("t4_code", 80'(err_code), 80'd1);
    chk("t4_nib3", 80'(pan_bcd[15:12]), 80'd0);
    chk("t4_drdy", 80'(digit_ready), 80'd0);
    send_digit(4'd5, 1'b0);
    chk("t4_ignored", 80'(pan_bcd), 80'h321);
    do_clear();
    chk_idle("t4_clear");

    // Too short: 11 digits
    for (int i = 0; i < 11; i++) send_digit(4'd7, 1'b0);
    do_end();
    chk("t5_short_err", 80'(pan_error), 80'd1);
    chk("t5_short_code", 80'(err_code), 80'd3);
    chk("t5_short_ready", 80'(pan_ready), 80'd0);
    do_clear();
    do_end();
    chk("t5_idle_end_code", 80'(err_code), 80'd3);
    chk("t5_idle_end_len", 80'(len_final), 80'd0);
    do_clear();

    // Minimum length: 11 digits plus the 12th with pan_end
    for (int i = 0; i < 11; i++) send_digit(4'd2, 1'b0);
    send_digit(4'd6, 1'b1);
    chk("t5_min_ready", 80'(pan_ready), 80'd1);
    chk("t5_min_len", 80'(len_final), 80'd12);
    chk("t5_min_bcd", 80'(pan_bcd), 80'h622222222222);
    do_clear();

    // Bad digit together with pan_end: BAD_DIGIT wins over SHORT
    for (int i = 0; i < 11; i++) send_digit(4'd3, 1'b0);
    send_digit(4'hB, 1'b1);
    chk("t5_prio_code", 80'(err_code), 80'd1);
    do_clear();

    // clear with a digit offered in the same cycle
    for (int i = 0; i < 8; i++) send_digit(4'd9, 1'b0);
    clear = 1'b1;
    digit_valid = 1'b1;
    digit_in = 4'd4;
    step();
    clear = 1'b0;
    digit_valid = 1'b0;
    digit_in = 4'd0;
    chk_idle("t6_clear");
    for (int i = 0; i < 12; i++) send_digit(4'd1, 1'b0);
    do_end();
    chk("t6_count_reset_len", 80'(len_final), 80'd12);
    do_clear();

    // Asynchronous reset mid-capture
    for (int i = 0; i < 5; i++) send_digit(4'd8, 1'b0);
    bcd_snap = pan_bcd;
    chk("t7_before_rst", 80'(bcd_snap), 80'h88888);
    #2 rst = 1'b1;
    #1;
    chk_idle("t7_async");
    #1 rst = 1'b0;
    step();
    chk_idle("t7_after");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
